reg_rd: RTL and testbench
=========================

# reg_rd

Operand-read stage of the cpu15 pipeline, the read side of the eight-entry register file. It accepts one decoded instruction per handshake, selects two source operands from the register file outputs, and presents them to execute with a one-cycle registered latency. An 8-bit busy scoreboard tracks registers with pending write-backs and stalls reads until the value is safe to use. With `REG_RD_BYPASS_EN` defined, a same-cycle write-back is forwarded instead of stalling.

## Interface
- WIDTH, 16, register/operand data width.
- CLK_RD  in  1  stage clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REG_0 … REG_7  in  WIDTH each  current register file contents.
- IN_VALID  in  1  decoded instruction present.
- IN_READY  out  1  stage accepts this cycle (combinational).
- N_SRC_A, N_SRC_B  in  3 each  source register indices.
- USE_A, USE_B  in  1 each  operand actually needed; unused operand never stalls.
- N_DST  in  3  destination register index.
- DST_WEN  in  1  instruction will write N_DST.
- WB_N_REG  in  3  write-back index, same cycle as the write port.
- WB_DATA  in  WIDTH  write-back data.
- WB_WEN  in  1  write-back commits at this edge.
- OUT_VALID  out  1  operands valid toward execute.
- OUT_READY  in  1  execute accepts.
- OP_A, OP_B  out  WIDTH each  registered operands.
- OUT_N_DST  out  3; OUT_DST_WEN  out  1  destination info passed along.
- BUSY  out  8  scoreboard; bit n = write to register n pending.

## Operation
- Accept = IN_VALID && IN_READY.
- IN_READY = (!OUT_VALID || OUT_READY) && !stall.
- Operand hazard (per used source s): BUSY[s] set. Without bypass, any hazard stalls. With bypass, hazard cleared when WB_WEN && WB_N_REG == s; operand then taken from WB_DATA.
- WAW hazard: DST_WEN && BUSY[N_DST] && !(WB_WEN && WB_N_REG == N_DST) stalls (one pending write per register).
- Operand mux: REG_[index], or WB_DATA when bypassed. An unused operand is still loaded from REG_[index], never stalls.
- Scoreboard per edge: clear BUSY[WB_N_REG] if WB_WEN; then set BUSY[N_DST] if accept && DST_WEN. Set wins on the same index. WB_WEN to a non-busy register is legal; no scoreboard change.
- Output register: loads OP_A/OP_B/OUT_N_DST/OUT_DST_WEN and sets OUT_VALID on accept. Clears OUT_VALID on OUT_READY without a new accept. Holds all outputs stable while OUT_VALID && !OUT_READY.

## Timing
- Reset values: OUT_VALID 0, OP_A 0, OP_B 0, OUT_N_DST 0, OUT_DST_WEN 0, BUSY 0. IN_READY is 1 after reset while IN_VALID's sources are not busy.
- Latency: accept at edge k → OUT_VALID, operands visible after edge k. Throughput is one per cycle with OUT_READY held high.
- Non-bypass RAW: the write commits at edge k, so BUSY clears at k and REG_x updates at k. The dependent instruction is accepted at edge k+1 at the earliest.
- Bypass RAW: the dependent instruction is accepted at edge k itself, with WB_DATA captured.
- RESET mid-operation: the in-flight output is discarded, the scoreboard is flushed, and the stage resumes next cycle.

## Configuration
- `REG_RD_BYPASS_EN` defined: WB_DATA is forwarded on index match, with no stall when the matching write-back is in the same cycle. The WAW release on same-cycle write-back applies in both builds.
- Undefined: no forwarding path. All RAW hazards stall until the cycle after write-back commits. WB_DATA is unused.

## Test plan
- Reset, then REG_3=0x1234, REG_5=0x00FF, accept A=3, B=5 → next cycle OP_A=0x1234, OP_B=0x00FF, OUT_VALID=1, BUSY=0x00.
- Accept DST_WEN=1, N_DST=2 → BUSY=0x04. Next instruction with USE_A, A=2 → IN_READY=0 until WB_WEN, WB_N_REG=2, WB_DATA=0xBEEF.
  - Bypass build: accepted in the WB cycle, OP_A=0xBEEF.
  - Non-bypass build: accepted one cycle later, OP_A=0xBEEF from REG_2.
- OUT_READY=0 for 3 cycles with OUT_VALID=1 → OP_A/OP_B unchanged, IN_READY=0. OUT_READY=1 → next accept proceeds in the same cycle.
- Same-edge WB_WEN to reg 4 and accept with DST_WEN to reg 4 (BUSY[4] was set) → accepted, BUSY[4] remains 1.
- USE_B=0 with B index busy → no stall, accepted immediately.
- Assert RESET while OUT_VALID=1 and BUSY=0x81 → OUT_VALID=0, BUSY=0x00, OP_A=OP_B=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_rd.sv
// +--------------------------------------------------------------------------+
// | reg_rd : operand-read stage of the cpu15 pipeline with busy scoreboard    |
// | Optional: REG_RD_BYPASS_EN forwards same-cycle write-back data            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module reg_rd #(
  parameter int WIDTH = 16
) (
  input  logic             CLK_RD,
  input  logic             RESET,
  input  logic [WIDTH-1:0] REG_0,
  input  logic [WIDTH-1:0] REG_1,
  input  logic [WIDTH-1:0] REG_2,
  input  logic [WIDTH-1:0] REG_3,
  input  logic [WIDTH-1:0] REG_4,
  input  logic [WIDTH-1:0] REG_5,
  input  logic [WIDTH-1:0] REG_6,
  input  logic [WIDTH-1:0] REG_7,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       N_SRC_A,
  input  logic [2:0]       N_SRC_B,
  input  logic             USE_A,
  input  logic             USE_B,
  input  logic [2:0]       N_DST,
  input  logic             DST_WEN,
  input  logic [2:0]       WB_N_REG,
  input  logic [WIDTH-1:0] WB_DATA,
  input  logic             WB_WEN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OP_A,
  output logic [WIDTH-1:0] OP_B,
  output logic [2:0]       OUT_N_DST,
  output logic             OUT_DST_WEN,
  output logic [7:0]       BUSY
);

  logic [WIDTH-1:0] rf [8];
  assign rf[0] = REG_0;
  assign rf[1] = REG_1;
  assign rf[2] = REG_2;
  assign rf[3] = REG_3;
  assign rf[4] = REG_4;
  assign rf[5] = REG_5;
  assign rf[6] = REG_6;
  assign rf[7] = REG_7;

  logic [7:0]       busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [2:0]       out_n_dst_q, out_n_dst_d;
  logic             out_dst_wen_q, out_dst_wen_d;

  logic             haz_a, haz_b, haz_waw, stall, accept;
  logic [WIDTH-1:0] opnd_a, opnd_b;

`ifdef REG_RD_BYPASS_EN
  logic wb_hit_a, wb_hit_b;
  assign wb_hit_a = WB_WEN && (WB_N_REG == N_SRC_A);
  assign wb_hit_b = WB_WEN && (WB_N_REG == N_SRC_B);
  assign haz_a    = USE_A && busy_q[N_SRC_A] && !wb_hit_a;
  assign haz_b    = USE_B && busy_q[N_SRC_B] && !wb_hit_b;
  // Unused operands always come from the register file, never the bypass.
  assign opnd_a   = (USE_A && wb_hit_a) ? WB_DATA : rf[N_SRC_A];
  assign opnd_b   = (USE_B && wb_hit_b) ? WB_DATA : rf[N_SRC_B];
`else
  logic unused_wb_data;
  assign unused_wb_data = ^WB_DATA;
  assign haz_a    = USE_A && busy_q[N_SRC_A];
  assign haz_b    = USE_B && busy_q[N_SRC_B];
  assign opnd_a   = rf[N_SRC_A];
  assign opnd_b   = rf[N_SRC_B];
`endif

  // Only one write per register may be outstanding; a same-edge retire frees the slot.
  assign haz_waw  = DST_WEN && busy_q[N_DST] && !(WB_WEN && (WB_N_REG == N_DST));
  assign stall    = haz_a || haz_b || haz_waw;
  assign IN_READY = (!out_valid_q || OUT_READY) && !stall;
  assign accept   = IN_VALID && IN_READY;

  always_comb begin
    busy_d        = busy_q;
    out_valid_d   = out_valid_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    out_n_dst_d   = out_n_dst_q;
    out_dst_wen_d = out_dst_wen_q;

    // Clear before set so a same-index issue keeps the bit asserted.
    if (WB_WEN) busy_d[WB_N_REG] = 1'b0;
    if (accept && DST_WEN) busy_d[N_DST] = 1'b1;

    if (accept) begin
      out_valid_d   = 1'b1;
      op_a_d        = opnd_a;
      op_b_d        = opnd_b;
      out_n_dst_d   = N_DST;
      out_dst_wen_d = DST_WEN;
    end else if (OUT_READY) begin
      out_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK_RD or posedge RESET) begin
    if (RESET) begin
      busy_q        <= '0;
      out_valid_q   <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      out_n_dst_q   <= '0;
      out_dst_wen_q <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      out_n_dst_q   <= out_n_dst_d;
      out_dst_wen_q <= out_dst_wen_d;
    end
  end

  assign BUSY        = busy_q;
  assign OUT_VALID   = out_valid_q;
  assign OP_A        = op_a_q;
  assign OP_B        = op_b_q;
  assign OUT_N_DST   = out_n_dst_q;
  assign OUT_DST_WEN = out_dst_wen_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_rd.sv
// +--------------------------------------------------------------------------+
// | tb_reg_rd : directed self-checking bench for reg_rd                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_reg_rd;

  localparam int WIDTH = 16;

  logic             CLK_RD;
  logic             RESET;
  logic [WIDTH-1:0] regs [8];
  logic             IN_VALID, IN_READY;
  logic [2:0]       N_SRC_A, N_SRC_B, N_DST, WB_N_REG;
  logic             USE_A, USE_B, DST_WEN, WB_WEN;
  logic [WIDTH-1:0] WB_DATA;
  logic             OUT_VALID, OUT_READY, OUT_DST_WEN;
  logic [WIDTH-1:0] OP_A, OP_B;
  logic [2:0]       OUT_N_DST;
  logic [7:0]       BUSY;

  int checks;
  int errors;

  reg_rd #(.WIDTH(WIDTH)) dut (
    .CLK_RD(CLK_RD), .RESET(RESET),
    .REG_0(regs[0]), .REG_1(regs[1]), .REG_2(regs[2]), .REG_3(regs[3]),
    .REG_4(regs[4]), .REG_5(regs[5]), .REG_6(regs[6]), .REG_7(regs[7]),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .N_SRC_A(N_SRC_A), .N_SRC_B(N_SRC_B), .USE_A(USE_A), .USE_B(USE_B),
    .N_DST(N_DST), .DST_WEN(DST_WEN),
    .WB_N_REG(WB_N_REG), .WB_DATA(WB_DATA), .WB_WEN(WB_WEN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OP_A(OP_A), .OP_B(OP_B), .OUT_N_DST(OUT_N_DST), .OUT_DST_WEN(OUT_DST_WEN),
    .BUSY(BUSY)
  );

  initial CLK_RD = 1'b0;
  always #5 CLK_RD = ~CLK_RD;

  task automatic tick;
    @(posedge CLK_RD);
    #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    tick();
    tick();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", OUT_VALID); end
    checks++; if (OP_A !== 16'h0000) begin errors++; $display("FAIL rst_op_a got %h exp 0000", OP_A); end
    checks++; if (OP_B !== 16'h0000) begin errors++; $display("FAIL rst_op_b got %h exp 0000", OP_B); end
    checks++; if (OUT_N_DST !== 3'd0 || OUT_DST_WEN !== 1'b0) begin errors++; $display("FAIL rst_dst got %0d/%b exp 0/0", OUT_N_DST, OUT_DST_WEN); end
    checks++; if (BUSY !== 8'h00) begin errors++; $display("FAIL rst_busy got %h exp 00", BUSY); end
    RESET = 1'b0;
    IN_VALID = 1'b1; USE_A = 1'b1; N_SRC_A = 3'd3;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", IN_READY); end
    IN_VALID = 1'b0; USE_A = 1'b0;
  endtask

  task automatic test_basic;
    IN_VALID = 1'b1; USE_A = 1'b1; USE_B = 1'b1; N_SRC_A = 3'd3; N_SRC_B = 3'd5;
    DST_WEN = 1'b0; N_DST = 3'd0;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b exp 1", IN_READY); end
    tick();
    IN_VALID = 1'b0;
    checks++; if (OP_A !== 16'h1234) begin errors++; $display("FAIL basic_op_a got %h exp 1234", OP_A); end
    checks++; if (OP_B !== 16'h00FF) begin errors++; $display("FAIL basic_op_b got %h exp 00ff", OP_B); end
    checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b exp 1", OUT_VALID); end
    checks++; if (BUSY !== 8'h00) begin errors++; $display("FAIL basic_busy got %h exp 00", BUSY); end
    tick();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", OUT_VALID); end
  endtask

  task automatic test_raw;
    IN_VALID = 1'b1; USE_A = 1'b1; USE_B = 1'b1; N_SRC_A = 3'd0; N_SRC_B = 3'd1;
    DST_WEN = 1'b1; N_DST = 3'd2;
    tick();
    checks++; if (BUSY !== 8'h04) begin errors++; $display("FAIL raw_busy_set got %h exp 04", BUSY); end
    checks++; if (OUT_N_DST !== 3'd2 || OUT_DST_WEN !== 1'b1) begin errors++; $display("FAIL raw_dst got %0d/%b exp 2/1", OUT_N_DST, OUT_DST_WEN); end
    N_SRC_A = 3'd2; USE_B = 1'b0; DST_WEN = 1'b0; N_DST = 3'd0;
    #1;
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL raw_stall got %b exp 0", IN_READY); end
    tick();
    checks++; if (OUT_VALID !== 1'b0 || BUSY !== 8'h04) begin errors++; $display("FAIL raw_hold got %b/%h exp 0/04", OUT_VALID, BUSY); end
    WB_WEN = 1'b1; WB_N_REG = 3'd2; WB_DATA = 16'hBEEF;
    #1;
`ifdef REG_RD_BYPASS_EN
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL raw_byp_ready got %b exp 1", IN_READY); end
    tick();
    regs[2] = 16'hBEEF; WB_WEN = 1'b0;
    checks++; if (BUSY !== 8'h00) begin errors++; $display("FAIL raw_byp_busy got %h exp 00", BUSY); end
`else
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle_ready got %b exp 0", IN_READY); end
    tick();
    regs[2] = 16'hBEEF; WB_WEN = 1'b0;
    #1;
    checks++; if (BUSY !== 8'h00 || IN_READY !== 1'b1) begin errors++; $display("FAIL raw_release got %h/%b exp 00/1", BUSY, IN_READY); end
    tick();
`endif
    checks++; if (OP_A !== 16'hBEEF) begin errors++; $display("FAIL raw_op_a got %h exp beef", OP_A); end
    checks++; if (OP_B !== 16'h0101) begin errors++; $display("FAIL raw_op_b_unused got %h exp 0101", OP_B); end
    checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL raw_out_valid got %b exp 1", OUT_VALID); end
  endtask

  task automatic test_backpressure;
    OUT_READY = 1'b0;
    USE_A = 1'b1; USE_B = 1'b1; N_SRC_A = 3'd5; N_SRC_B = 3'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, IN_READY); end
      tick();
      checks++; if (OP_A !== 16'hBEEF || OP_B !== 16'h0101 || OUT_VALID !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] got %h/%h/%b exp beef/0101/1", i, OP_A, OP_B, OUT_VALID);
      end
    end
    OUT_READY = 1'b1;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", IN_READY); end
    tick();
    IN_VALID = 1'b0;
    checks++; if (OP_A !== 16'h00FF || OP_B !== 16'h1234) begin errors++; $display("FAIL bp_next got %h/%h exp 00ff/1234", OP_A, OP_B); end
  endtask

  task automatic test_waw;
    IN_VALID = 1'b1; USE_A = 1'b0; USE_B = 1'b0; DST_WEN = 1'b1; N_DST = 3'd4;
    tick();
    checks++; if (BUSY !== 8'h10) begin errors++; $display("FAIL waw_busy_set got %h exp 10", BUSY); end
    #1;
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL waw_stall got %b exp 0", IN_READY); end
    WB_WEN = 1'b1; WB_N_REG = 3'd4; WB_DATA = 16'h4444;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL waw_release got %b exp 1", IN_READY); end
    tick();
    regs[4] = 16'h4444; WB_WEN = 1'b0; DST_WEN = 1'b0;
    checks++; if (BUSY !== 8'h10) begin errors++; $display("FAIL waw_busy_kept got %h exp 10", BUSY); end
    checks++; if (OUT_N_DST !== 3'd4 || OUT_DST_WEN !== 1'b1) begin errors++; $display("FAIL waw_dst got %0d/%b exp 4/1", OUT_N_DST, OUT_DST_WEN); end
  endtask

  task automatic test_unused_src;
    USE_A = 1'b1; N_SRC_A = 3'd3; USE_B = 1'b0; N_SRC_B = 3'd4; DST_WEN = 1'b0; N_DST = 3'd0;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL unused_ready got %b exp 1", IN_READY); end
    tick();
    IN_VALID = 1'b0;
    checks++; if (OP_A !== 16'h1234 || OP_B !== 16'h4444) begin errors++; $display("FAIL unused_ops got %h/%h exp 1234/4444", OP_A, OP_B); end
    WB_WEN = 1'b1; WB_N_REG = 3'd4; WB_DATA = 16'h5555;
    tick();
    regs[4] = 16'h5555; WB_WEN = 1'b0;
    checks++; if (BUSY !== 8'h00) begin errors++; $display("FAIL unused_wb_clear got %h exp 00", BUSY); end
  endtask

  task automatic test_async_reset;
    IN_VALID = 1'b1; USE_A = 1'b0; USE_B = 1'b0; N_SRC_A = 3'd3; N_SRC_B = 3'd5;
    DST_WEN = 1'b1; N_DST = 3'd7;
    tick();
    N_DST = 3'd0; N_SRC_A = 3'd5; N_SRC_B = 3'd3;
    tick();
    IN_VALID = 1'b0; DST_WEN = 1'b0; OUT_READY = 1'b0;
    checks++; if (BUSY !== 8'h81 || OUT_VALID !== 1'b1 || OP_A !== 16'h00FF) begin
      errors++; $display("FAIL ares_setup got %h/%b/%h exp 81/1/00ff", BUSY, OUT_VALID, OP_A);
    end
    #2;
    RESET = 1'b1;
    #1;
    checks++; if (OUT_VALID !== 1'b0 || BUSY !== 8'h00) begin errors++; $display("FAIL ares_flush got %b/%h exp 0/00", OUT_VALID, BUSY); end
    checks++; if (OP_A !== 16'h0000 || OP_B !== 16'h0000 || OUT_N_DST !== 3'd0) begin
      errors++; $display("FAIL ares_ops got %h/%h/%0d exp 0000/0000/0", OP_A, OP_B, OUT_N_DST);
    end
    @(negedge CLK_RD);
    RESET = 1'b0; OUT_READY = 1'b1;
    IN_VALID = 1'b1; USE_A = 1'b1; USE_B = 1'b1; N_SRC_A = 3'd3; N_SRC_B = 3'd5;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL ares_resume_ready got %b exp 1", IN_READY); end
    tick();
    IN_VALID = 1'b0;
    checks++; if (OP_A !== 16'h1234 || OUT_VALID !== 1'b1) begin errors++; $display("FAIL ares_resume got %h/%b exp 1234/1", OP_A, OUT_VALID); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    RESET = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    N_SRC_A = 3'd0; N_SRC_B = 3'd0; USE_A = 1'b0; USE_B = 1'b0;
    N_DST = 3'd0; DST_WEN = 1'b0; WB_N_REG = 3'd0; WB_DATA = '0; WB_WEN = 1'b0;
    regs[0] = 16'h0A0A; regs[1] = 16'h0101; regs[2] = 16'h1111; regs[3] = 16'h1234;
    regs[4] = 16'h0404; regs[5] = 16'h00FF; regs[6] = 16'h0606; regs[7] = 16'h0707;

    test_reset();
    test_basic();
    test_raw();
    test_backpressure();
    test_waw();
    test_unused_src();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
